// File: rtl/ntt_ram_sched.sv
// Address/control scheduler for an in-place 256-point NTT / inverse NTT over a dual-port coefficient RAM.
// Define NTT_SCHED_PERF_EN to add the perf_cycles / perf_stall counters.
module ntt_ram_sched #(
   parameter int BF_LAT = 4,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              inverse,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic [ADDR_W-1:0] ram_addr_b,
   output logic              ram_we_a,
   output logic              ram_we_b,
   output logic [7:0]        zeta_idx,
   output logic              bf_in_valid,
   output logic              bf_inverse,
   output logic [2:0]        layer
`ifdef NTT_SCHED_PERF_EN
   ,
   output logic [15:0]       perf_cycles,
   output logic [15:0]       perf_stall
`endif
);

   localparam int L = BF_LAT + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {ACT_NONE, ACT_READ, ACT_WRITE, ACT_LEND} act_t;
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] z;
   } rd_t;

   state_t              state_q, state_d;
   logic [7:0]          b_q, b_d;
   logic [2:0]          layer_q, layer_d;
   logic                inv_q, inv_d;
   logic [L-1:0]        dlValid_q, dlValid_d;
   logic [L-1:0][7:0]   dlA_q, dlA_d;
   logic [L-1:0][7:0]   dlB_q, dlB_d;
   act_t                actCur, actNext;
   rd_t                 rdNext;

   // Writes drain the delay-line tail first; reads fill the gaps; a layer ends only once the line is empty.
   function automatic act_t decide(input state_t st, input logic bHi, input logic [L-1:0] vld);
      act_t act;
      act = ACT_NONE;
      if (st == S_RUN) begin
         if (vld[L-1])
            act = ACT_WRITE;
         else if (!bHi)
            act = ACT_READ;
         else if (vld == '0)
            act = ACT_LEND;
      end
      return act;
   endfunction

   // Pair span is 2^s: forward shrinks the span each layer, inverse grows it.
   function automatic rd_t rdAddr(input logic [7:0] bIdx, input logic [2:0] lay, input logic inv);
      rd_t        r;
      logic [2:0] s;
      logic [7:0] len;
      logic [7:0] mask;
      logic [7:0] g;
      s    = inv ? lay : (3'd7 - lay);
      len  = 8'd1 << s;
      mask = len - 8'd1;
      g    = bIdx >> s;
      r.a  = ((g << s) << 1) | (bIdx & mask);
      r.b  = r.a + len;
      if (inv)
         r.z = 8'((9'd256 >> lay) - 9'd1 - {1'b0, g});
      else
         r.z = (8'd1 << lay) + g;
      return r;
   endfunction

   // Outputs are registered, so the action for the coming cycle is decided from the next-state values.
   always_comb begin
      actCur    = decide(state_q, b_q[7], dlValid_q);
      state_d   = state_q;
      b_d       = b_q;
      layer_d   = layer_q;
      inv_d     = inv_q;
      dlValid_d = {dlValid_q[L-2:0], 1'b0};
      dlA_d     = {dlA_q[L-2:0], 8'd0};
      dlB_d     = {dlB_q[L-2:0], 8'd0};
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               b_d       = 8'd0;
               layer_d   = 3'd0;
               inv_d     = inverse;
               dlValid_d = '0;
            end
         end
         S_RUN: begin
            case (actCur)
               ACT_READ: begin
                  dlValid_d[0] = 1'b1;
                  dlA_d[0]     = ram_addr_a;
                  dlB_d[0]     = ram_addr_b;
                  b_d          = b_q + 8'd1;
               end
               ACT_LEND: begin
                  if (layer_q == 3'd7) begin
                     state_d = S_DONE;
                  end else begin
                     layer_d = layer_q + 3'd1;
                     b_d     = 8'd0;
                  end
               end
               default: ;
            endcase
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      actNext = decide(state_d, b_d[7], dlValid_d);
      rdNext  = rdAddr(b_d, layer_d, inv_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         b_q         <= 8'd0;
         layer_q     <= 3'd0;
         inv_q       <= 1'b0;
         dlValid_q   <= '0;
         dlA_q       <= '0;
         dlB_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_addr_a  <= '0;
         ram_addr_b  <= '0;
         ram_we_a    <= 1'b0;
         ram_we_b    <= 1'b0;
         zeta_idx    <= 8'd0;
         bf_in_valid <= 1'b0;
         bf_inverse  <= 1'b0;
         layer       <= 3'd0;
      end else begin
         state_q     <= state_d;
         b_q         <= b_d;
         layer_q     <= layer_d;
         inv_q       <= inv_d;
         dlValid_q   <= dlValid_d;
         dlA_q       <= dlA_d;
         dlB_q       <= dlB_d;
         busy        <= (state_d == S_RUN);
         done        <= (state_d == S_DONE);
         ram_we_a    <= (actNext == ACT_WRITE);
         ram_we_b    <= (actNext == ACT_WRITE);
         bf_in_valid <= (actCur == ACT_READ);
         bf_inverse  <= inv_d;
         layer       <= layer_d;
         if (actNext == ACT_WRITE) begin
            ram_addr_a <= dlA_d[L-1];
            ram_addr_b <= dlB_d[L-1];
         end else if (actNext == ACT_READ) begin
            ram_addr_a <= rdNext.a;
            ram_addr_b <= rdNext.b;
            zeta_idx   <= rdNext.z;
         end
      end
   end

`ifdef NTT_SCHED_PERF_EN
   // Stall cycles include the empty layer-end cycle as well as drain waits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= 16'd0;
         perf_stall  <= 16'd0;
      end else if (state_q == S_IDLE) begin
         if (start) begin
            perf_cycles <= 16'd0;
            perf_stall  <= 16'd0;
         end
      end else begin
         perf_cycles <= perf_cycles + 16'd1;
         if (state_q == S_RUN && (actCur == ACT_NONE || actCur == ACT_LEND))
            perf_stall <= perf_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ntt_ram_sched.sv
// Scoreboard bench for ntt_ram_sched: expected reads/writes/done are queued at issue, a negedge monitor checks them,
// and a RAM + toy butterfly harness compares the final RAM against a software transform.
`timescale 1ns/1ps
module tb_ntt_ram_sched;
   localparam int BF_LAT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       inverse = 1'b0;
   logic       busy, done, ram_we_a, ram_we_b, bf_in_valid, bf_inverse;
   logic [7:0] ram_addr_a, ram_addr_b, zeta_idx;
   logic [2:0] layer;
`ifdef NTT_SCHED_PERF_EN
   logic [15:0] perf_cycles, perf_stall;
`endif

   always #5 clk = ~clk;

   ntt_ram_sched #(.BF_LAT(BF_LAT), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
      .busy(busy), .done(done),
      .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
      .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
      .zeta_idx(zeta_idx), .bf_in_valid(bf_in_valid),
      .bf_inverse(bf_inverse), .layer(layer)
`ifdef NTT_SCHED_PERF_EN
      , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] z;
      logic [2:0] l;
   } rdExp_t;
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
   } wrExp_t;

   rdExp_t rdQ[$];
   wrExp_t wrQ[$];
   int     doneQ[$];
   logic   invQ[$];
   int     checks = 0;
   int     passes = 0;
   int     cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual == expected)
         passes++;
      else
         $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
   endtask

   function automatic rdExp_t pairOf(input int l, input int b, input logic inv);
      rdExp_t r;
      int len, g, o, a;
      len = inv ? (1 << l) : (128 >> l);
      g   = b / len;
      o   = b % len;
      a   = 2 * g * len + o;
      r.a = 8'(a);
      r.b = 8'(a + len);
      r.z = inv ? 8'((256 >> l) - 1 - g) : 8'((1 << l) + g);
      r.l = 3'(l);
      return r;
   endfunction

   function automatic logic [23:0] seed(input int i);
      return 24'(i * 40503 + 17);
   endfunction

   function automatic logic [47:0] bfFn(input logic [23:0] a, input logic [23:0] b,
                                        input logic [7:0] z, input logic inv);
      logic [23:0] x, y;
      if (inv) begin
         x = a + b;
         y = (a - b) ^ {z, z, z};
      end else begin
         x = a + b + {16'd0, z};
         y = a - b + {12'd0, z, 4'd0};
      end
      return {x, y};
   endfunction

   // RAM + butterfly harness: 1-cycle RAM read, zeta ROM registered, BF_LAT-stage pipeline to din
   logic [23:0] mem [256];
   logic [23:0] gold [256];
   logic [23:0] doutA, doutB;
   logic [7:0]  zetaQ;
   logic [47:0] pipe [BF_LAT];
   logic        memLoad = 1'b0;

   always @(posedge clk) begin
      if (memLoad) begin
         for (int i = 0; i < 256; i++) mem[i] <= seed(i);
      end else begin
         if (ram_we_a) mem[ram_addr_a] <= pipe[BF_LAT-1][47:24];
         if (ram_we_b) mem[ram_addr_b] <= pipe[BF_LAT-1][23:0];
      end
      doutA <= mem[ram_addr_a];
      doutB <= mem[ram_addr_b];
      zetaQ <= zeta_idx;
      pipe[0] <= bfFn(doutA, doutB, zetaQ, bf_inverse);
      for (int i = 1; i < BF_LAT; i++) pipe[i] <= pipe[i-1];
   end

   // Monitor: a read is recognised by bf_in_valid one cycle after its addresses were presented
   logic [7:0] prevA = 8'd0, prevB = 8'd0, prevZ = 8'd0;
   logic [2:0] prevL = 3'd0;
   logic       prevBusy = 1'b0;
   int         c0 = 0, rdIdx = 0, wrIdx = 0, doneCount = 0, lastDoneCyc = 0;
   logic [7:0] logA [1024], logB [1024], logZ [1024];
   int         wrOff [8];
   rdExp_t     eR;
   wrExp_t     eW;

   always @(negedge clk) begin
      if (rst_n) begin
         if (busy && !prevBusy) begin
            c0    = cyc;
            rdIdx = 0;
            wrIdx = 0;
         end
         if (bf_in_valid) begin
            if (rdQ.size() == 0) begin
               checkOutput("read_unexpected", {prevL, prevA, prevB, prevZ}, 0);
            end else begin
               eR = rdQ.pop_front();
               checkOutput("read_tuple", {prevL, prevA, prevB, prevZ}, {eR.l, eR.a, eR.b, eR.z});
            end
            if (rdIdx < 1024) begin
               logA[rdIdx] = prevA;
               logB[rdIdx] = prevB;
               logZ[rdIdx] = prevZ;
            end
            rdIdx++;
         end
         if (ram_we_a || ram_we_b) begin
            checkOutput("we_pair", {ram_we_a, ram_we_b}, 2'b11);
            if (wrQ.size() == 0) begin
               checkOutput("write_unexpected", {ram_addr_a, ram_addr_b}, 0);
            end else begin
               eW = wrQ.pop_front();
               checkOutput("write_addr", {ram_addr_a, ram_addr_b}, {eW.a, eW.b});
            end
            if (wrIdx < 8) wrOff[wrIdx] = cyc - c0;
            wrIdx++;
         end
         if (done) begin
            doneCount++;
            lastDoneCyc = cyc;
            checkOutput("done_busy", busy, 0);
            if (doneQ.size() == 0 || invQ.size() == 0) begin
               checkOutput("done_unexpected", cyc - c0, 0);
            end else begin
               checkOutput("done_offset", cyc - c0, doneQ.pop_front());
               checkOutput("bf_inverse", bf_inverse, invQ.pop_front());
            end
         end
      end
      prevA    = ram_addr_a;
      prevB    = ram_addr_b;
      prevZ    = zeta_idx;
      prevL    = layer;
      prevBusy = busy;
   end

   task automatic applyStimulus(input logic inv);
      rdExp_t r;
      wrExp_t w;
      for (int l = 0; l < 8; l++) begin
         for (int b = 0; b < 128; b++) begin
            r   = pairOf(l, b, inv);
            w.a = r.a;
            w.b = r.b;
            rdQ.push_back(r);
            wrQ.push_back(w);
         end
      end
      doneQ.push_back(2072);
      invQ.push_back(inv);
      inverse = inv;
      start   = 1'b1;
      @(posedge clk); #2;
      start   = 1'b0;
      inverse = ~inv;
   endtask

   task automatic pulseStartWhileBusy();
      start   = 1'b1;
      inverse = 1'b1;
      @(posedge clk); #2;
      start   = 1'b0;
      inverse = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      int startCnt, n;
      startCnt = doneCount;
      n = 0;
      while (doneCount == startCnt && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      checkOutput("done_seen", doneCount - startCnt, 1);
   endtask

   task automatic checkAfterTransform();
      checkOutput("rdQ_empty", rdQ.size(), 0);
      checkOutput("wrQ_empty", wrQ.size(), 0);
      checkOutput("reads_total", rdIdx, 1024);
      checkOutput("writes_total", wrIdx, 1024);
`ifdef NTT_SCHED_PERF_EN
      checkOutput("perf_cycles", perf_cycles, 2073);
      checkOutput("perf_stall", perf_stall, 24);
`endif
   endtask

   task automatic runGolden();
      rdExp_t p;
      logic [47:0] r;
      for (int i = 0; i < 256; i++) gold[i] = seed(i);
      for (int l = 0; l < 8; l++) begin
         for (int b = 0; b < 128; b++) begin
            p = pairOf(l, b, 1'b0);
            r = bfFn(gold[p.a], gold[p.b], p.z, 1'b0);
            gold[p.a] = r[47:24];
            gold[p.b] = r[23:0];
         end
      end
   endtask

   initial begin
      int dPrev, n;
      $display("[TB] ntt_ram_sched bench start");
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_we", {ram_we_a, ram_we_b}, 0);
      checkOutput("rst_addr", {ram_addr_a, ram_addr_b}, 0);
      checkOutput("rst_zeta", zeta_idx, 0);
      checkOutput("rst_layer", layer, 0);
      checkOutput("rst_bf", {bf_in_valid, bf_inverse}, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      $display("[TB] forward transform with start pulses while busy");
      applyStimulus(1'b0);
      repeat (50) @(posedge clk);
      #2;
      pulseStartWhileBusy();
      repeat (600) @(posedge clk);
      #2;
      pulseStartWhileBusy();
      waitDone(2300);
      checkAfterTransform();
      for (int i = 0; i < 5; i++) begin
         checkOutput("fwd_first_a", logA[i], i);
         checkOutput("fwd_first_b", logB[i], 128 + i);
         checkOutput("fwd_first_z", logZ[i], 1);
         checkOutput("fwd_first_wr_cycle", wrOff[i], 5 + i);
      end
      checkOutput("fwd_l7_b5", {logA[901], logB[901], logZ[901]}, {8'd10, 8'd11, 8'd133});

      $display("[TB] inverse transform started one cycle after done");
      dPrev = lastDoneCyc;
      applyStimulus(1'b1);
      @(negedge clk); #1;
      checkOutput("restart_gap", c0 - dPrev, 2);
      waitDone(2300);
      checkAfterTransform();
      checkOutput("inv_l0_b0", {logA[0], logB[0], logZ[0]}, {8'd0, 8'd1, 8'd255});
      checkOutput("inv_l7_b0", {logA[896], logB[896], logZ[896]}, {8'd0, 8'd128, 8'd1});

      $display("[TB] reset abort at C0+700");
      applyStimulus(1'b0);
      @(negedge clk); #1;
      n = 0;
      while (cyc - c0 < 700 && n < 1000) begin
         @(posedge clk); #2;
         n++;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("abort_we", {ram_we_a, ram_we_b}, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_bfv", bf_in_valid, 0);
      rdQ.delete();
      wrQ.delete();
      doneQ.delete();
      invQ.delete();
      repeat (3) @(posedge clk);
      #2;
      checkOutput("abort_hold_we", {ram_we_a, ram_we_b}, 0);
      rst_n = 1'b1;
      @(posedge clk); #2;
      memLoad = 1'b1;
      @(posedge clk); #2;
      memLoad = 1'b0;
      runGolden();

      $display("[TB] clean forward transform against golden model");
      applyStimulus(1'b0);
      waitDone(2300);
      checkAfterTransform();
      for (int i = 0; i < 256; i++) checkOutput("ram_final", mem[i], gold[i]);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
